// File: rtl/fbha_pkg.sv
// Shared types and constants for the fbha requester slice.
//   FBHA_N / FBHA_TAG_W / FBHA_DEPTH : default operand width, tag width, result FIFO depth.
//   OP_ADD / OP_SUB                  : encoding of the in_sub request bit.
//   fbha_result_t                    : one buffered result {sum, cout, ovf, tag}.
package fbha_pkg;

    localparam int unsigned FBHA_N     = 32;
    localparam int unsigned FBHA_TAG_W = 4;
    localparam int unsigned FBHA_DEPTH = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Field widths follow the package defaults; the requester's N and TAG_W must match them.
    typedef struct packed {
        logic [FBHA_N-1:0]     sum;
        logic                  cout;
        logic                  ovf;
        logic [FBHA_TAG_W-1:0] tag;
    } fbha_result_t;

endpackage

// File: rtl/fbha_result_fifo.sv
// In-order result FIFO for fbha_requester.
//   clk, rst   : clock, asynchronous active-high reset (clears storage, pointers, count).
//   push       : write push_data at the tail this cycle.
//   push_data  : result to store.
//   pop        : drop the head entry this cycle (caller ensures count != 0).
//   count      : number of valid entries, 0..DEPTH.
//   head       : combinational read of the head entry.
module fbha_result_fifo
    import fbha_pkg::*;
#(
    parameter int unsigned DEPTH = FBHA_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  fbha_result_t     push_data,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output fbha_result_t     head
);

    fbha_result_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Explicit wrap so non-power-of-two depths stay modulo DEPTH.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fbha_requester.sv
// Initiator-side controller for the fbha_adder (2-cycle start->done latency).
//   in_*        : request stream {a, b, cin, sub, tag} with valid/ready.
//   add_*       : issue port to the adder (start/a/b/cin out, sum/cout/done in).
//   out_*       : in-order result stream {sum, cout, ovf, tag} with valid/ready.
//   err_spurious: sticky flag, add_done seen with nothing in flight; cleared by rst only.
// Credits: a request is accepted only if FIFO occupancy plus in-flight ops leaves a free slot,
// so every capture finds room and the adder never needs to stall.
module fbha_requester
    import fbha_pkg::*;
#(
    parameter int unsigned N     = FBHA_N,
    parameter int unsigned TAG_W = FBHA_TAG_W,
    parameter int unsigned DEPTH = FBHA_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             add_start,
    output logic [N-1:0]     add_a,
    output logic [N-1:0]     add_b,
    output logic             add_cin,
    input  logic [N-1:0]     add_sum,
    input  logic             add_cout,
    input  logic             add_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag,
    output logic             err_spurious
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic             a_msb;
        logic             b_msb;
    } side_t;

    logic             acc;
    logic             is_sub;
    logic [N-1:0]     b_eff;
    logic             inflight_nz;
    logic             capture;
    logic             pop;
    logic             ovf;
    logic [1:0]       inflight_q;
    logic [1:0]       inflight_d;
    logic             err_q;
    side_t            s1_q;
    side_t            s2_q;
    logic [CNT_W-1:0] fifo_count;
    fbha_result_t     push_data;
    fbha_result_t     head;

    // Ready looks only at registered state, never at in_valid or out_ready.
    assign in_ready = (32'(fifo_count) + 32'(inflight_q)) < DEPTH;
    assign acc      = in_valid & in_ready;

    // Subtract is A + ~B + 1.
    assign is_sub    = (in_sub == OP_SUB);
    assign b_eff     = is_sub ? ~in_b : in_b;
    assign add_start = acc;
    assign add_a     = in_a;
    assign add_b     = b_eff;
    assign add_cin   = is_sub ? 1'b1 : in_cin;

    assign inflight_nz = (inflight_q != 2'd0);
    assign capture     = add_done & inflight_nz;

    // Side pipeline: stage 2 lines up with the adder's done for the same op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= '{valid: acc, tag: in_tag, a_msb: in_a[N-1], b_msb: b_eff[N-1]};
            s2_q <= s1_q;
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        case ({acc, capture})
            2'b10:   inflight_d = inflight_q + 2'd1;
            2'b01:   inflight_d = inflight_q - 2'd1;
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= 2'd0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            if (add_done && !inflight_nz) begin
                err_q <= 1'b1;
            end
        end
    end

    // Same-sign operands producing a different-sign sum.
    assign ovf = (s2_q.a_msb == s2_q.b_msb) & (add_sum[N-1] != s2_q.a_msb);

    assign push_data = '{sum: add_sum, cout: add_cout, ovf: ovf, tag: s2_q.tag};
    assign pop       = out_valid & out_ready;

    fbha_result_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (capture),
        .push_data(push_data),
        .pop      (pop),
        .count    (fifo_count),
        .head     (head)
    );

    assign out_valid    = (fifo_count != '0);
    assign out_sum      = head.sum;
    assign out_cout     = head.cout;
    assign out_ovf      = head.ovf;
    assign out_tag      = head.tag;
    assign err_spurious = err_q;

    // A legitimate done always has its side-pipeline entry in stage 2.
    a_done_aligned: assert property (@(posedge clk) disable iff (rst)
        capture |-> s2_q.valid);

endmodule

// File: doc/fbha_requester.md
# fbha_requester

Initiator-side controller for the fixed-block hybrid adder (`fbha_adder`, N=32). It does four things:
- Accepts operand pairs on a valid/ready stream.
- Converts subtract requests into add-with-inverted-B.
- Issues each pair to the adder's `start`/`done` port.
- Buffers returned results in an in-order FIFO, presented on a valid/ready stream with tag, carry and signed-overflow flags.

Credit accounting guarantees every issued operation has a reserved result slot, so the adder is never stalled and no result is dropped.

## Interface
- `N`, 32, operand/result width; must match the adder.
- `TAG_W`, 4, width of the user tag carried alongside each operation.
- `DEPTH`, 4, result FIFO entries; legal range 2..16.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  request accepted when `in_valid & in_ready`.
- `in_a`  in  N  operand A.
- `in_b`  in  N  operand B.
- `in_cin`  in  1  carry-in, used for add only.
- `in_sub`  in  1  1 = compute A−B, 0 = compute A+B+cin.
- `in_tag`  in  TAG_W  user tag, returned with the result.
- `add_start`  out  1  issue pulse to the adder.
- `add_a`  out  N  operand A to the adder.
- `add_b`  out  N  operand B to the adder.
- `add_cin`  out  1  carry-in to the adder.
- `add_sum`  in  N  adder `Sum`.
- `add_cout`  in  1  adder `Cout`.
- `add_done`  in  1  adder `done`.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  result consumed when `out_valid & out_ready`.
- `out_sum`  out  N  result value.
- `out_cout`  out  1  carry out; for subtract, 1 = no borrow.
- `out_ovf`  out  1  signed two's-complement overflow.
- `out_tag`  out  TAG_W  tag of this result.
- `err_spurious`  out  1  sticky: `add_done` arrived with nothing in flight.

## Operation
- **Accept:** `acc = in_valid & in_ready`.
- **Credit check:** `in_ready = (fifo_count + inflight) < DEPTH`, with `inflight` in 0..2. The check is combinational from registered state only; `in_ready` does not depend on `in_valid` or `out_ready` in the same cycle.
- **Issue (combinational on `acc`):**
  - `add_start = acc`.
  - `add_a = in_a`.
  - `add_b = in_sub ? ~in_b : in_b`.
  - `add_cin = in_sub ? 1 : in_cin`.
  - When not accepting, `add_a`, `add_b` and `add_cin` are don't-care.
- **Side pipeline:** a 2-stage shift register carries {valid, tag, a[N-1], b_eff[N-1]} per issue. Stage 2 aligns with `add_done`.
- **Capture:** when `add_done` is high, write {`add_sum`, `add_cout`, ovf, tag} into the FIFO.
  - ovf = (a_msb == b_eff_msb) & (`add_sum[N-1]` != a_msb).
  - The credit rule guarantees the FIFO is never full at capture.
- **In-flight counter:**
  - Increment on `acc`; decrement on `add_done`; both in the same cycle leaves it unchanged.
  - If `add_done` arrives while `inflight == 0`: set `err_spurious`, write nothing, leave the counter at 0.
- **FIFO:**
  - `out_*` is driven from the head entry. `out_valid = (fifo_count != 0)`.
  - Pop on `out_valid & out_ready`.
  - A simultaneous push and pop leaves the count unchanged. Pointers wrap modulo DEPTH.
- **Ordering:** results leave strictly in acceptance order.

## Timing
- Request accepted in cycle c → `add_start` high in cycle c → `add_done` high in cycle c+2 → result visible on `out_*` with `out_valid` in cycle c+3.
- Minimum request-to-result latency is 3 cycles.
- Back-to-back acceptance is supported: one request per cycle is sustained while `out_ready` stays high.
- With `out_ready` held low, exactly DEPTH requests are accepted; then `in_ready` drops.
- A pop in cycle k restores `in_ready` in cycle k+1.
- **Reset values:**
  - `in_ready = 1`.
  - `add_start = 0`.
  - `out_valid = 0`, with `out_sum`, `out_cout`, `out_ovf`, `out_tag` all 0.
  - `err_spurious = 0`.
  - Counters, pointers and side pipeline cleared.
- **Reset mid-operation:** in-flight and buffered results are discarded; no `out_valid` is produced for them. The adder shares `rst`, so it discards its pipeline too.
- `err_spurious` clears only on `rst`.

## Structure
- Package `fbha_pkg` holds:
  - default N, TAG_W, DEPTH constants;
  - the `fbha_result_t` struct {sum, cout, ovf, tag};
  - the operation encoding constants OP_ADD=0, OP_SUB=1.
- Sub-module `fbha_result_fifo` is a synchronous FIFO of `fbha_result_t`, parameterised by DEPTH.
  - Ports: push, pop, count, head.
  - Registered storage with a combinational head read.
- The top level holds the credit logic, operand conditioning, side pipeline, and an instance of `fbha_adder` in the bench only. The requester itself does not instantiate the adder.

## Test plan
- **Add:** A=0xFFFF_FFFF, B=0x0000_0001, cin=0, tag=3 → out_sum=0, cout=1, ovf=0, tag=3, `out_valid` at c+3.
- **Subtract:** A=5, B=7, sub=1 → sum=0xFFFF_FFFE, cout=0 (borrow), ovf=0. Then A=0x8000_0000, B=1, sub=1 → sum=0x7FFF_FFFF, ovf=1, cout=1.
- **Streaming:** 8 back-to-back requests with tags 0..7 and `out_ready=1` → `in_ready` never drops; results emerge in tag order 0..7 in consecutive cycles starting at c+3.
- **Backpressure:** `out_ready=0` with continuous `in_valid` → exactly 4 accepts, `in_ready` low from the 5th cycle. Raise `out_ready` for 1 cycle → one pop, `in_ready` high the next cycle, no result lost or reordered.
- **Reset:** assert `rst` with 2 in flight and 2 buffered → all outputs return to reset values immediately; no stale result appears after deassertion.
- **Spurious done:** inject `add_done` with the FIFO empty and nothing in flight → `err_spurious=1` and sticky, `out_valid` stays 0.
